// File: rtl/dma_vram_fill_pkg.sv
// rtl/dma_vram_fill_pkg.sv - shared command modes, FSM states and text attribute bit positions
package dma_vram_fill_pkg;

    typedef enum logic [1:0] {
        MODE_FILL   = 2'd0,
        MODE_INCR   = 2'd1,
        MODE_PUTC   = 2'd2,
        MODE_SETCUR = 2'd3
    } cmd_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } fill_state_e;

    // Attribute byte layout, also consumed by the text renderer
    localparam int ATTR_FG_B  = 0;
    localparam int ATTR_FG_G  = 1;
    localparam int ATTR_FG_R  = 2;
    localparam int ATTR_BG_B  = 4;
    localparam int ATTR_BG_G  = 5;
    localparam int ATTR_BG_R  = 6;
    localparam int ATTR_BLINK = 7;

endpackage

// File: rtl/dma_vram_fill_if.sv
// rtl/dma_vram_fill_if.sv - command handshake bundle for the VRAM fill engine
interface dma_vram_fill_if #(
    parameter int ADR_W = 12
);
    logic             i_cmd_valid;
    logic             o_cmd_ready;
    logic [1:0]       i_cmd_mode;
    logic [7:0]       i_cmd_char;
    logic [7:0]       i_cmd_attr;
    logic [ADR_W-1:0] i_cmd_adr;
    logic [ADR_W-1:0] i_cmd_len;

    modport master (
        output i_cmd_valid, i_cmd_mode, i_cmd_char, i_cmd_attr, i_cmd_adr, i_cmd_len,
        input  o_cmd_ready
    );

    modport slave (
        input  i_cmd_valid, i_cmd_mode, i_cmd_char, i_cmd_attr, i_cmd_adr, i_cmd_len,
        output o_cmd_ready
    );
endinterface

// File: rtl/dma_vram_fill_adr_wrap.sv
// rtl/dma_vram_fill_adr_wrap.sv - next screen cell address, wrapping at the last visible cell
module vram_adr_wrap #(
    parameter int ADR_W = 12,
    parameter int CELLS = 2400
) (
    input  logic [ADR_W-1:0] adr,
    output logic [ADR_W-1:0] adr_next
);
    localparam logic [ADR_W-1:0] LAST = ADR_W'(CELLS - 1);

    assign adr_next = (adr >= LAST) ? '0 : adr + ADR_W'(1);
endmodule

// File: rtl/dma_vram_fill.sv
// rtl/dma_vram_fill.sv - text-mode VRAM/CRAM fill, increment, putc and cursor engine
module dma_vram_fill
    import dma_vram_fill_pkg::*;
#(
    parameter int COLS  = 80,
    parameter int ROWS  = 30,
    parameter int ADR_W = 12
) (
    input  logic             i_clk,
    input  logic             i_rst,
    dma_vram_fill_if.slave   cmd,
    output logic [7:0]       o_vram_data,
    output logic [7:0]       o_cram_data,
    output logic [ADR_W-1:0] o_vram_adr,
    output logic             o_vram_we,
    output logic [ADR_W-1:0] o_cursor_adr,
    output logic             o_cursor_on,
    output logic             o_busy,
    output logic             o_done
);
    localparam int               CELLS = COLS * ROWS;
    localparam logic [ADR_W-1:0] LAST  = ADR_W'(CELLS - 1);

    fill_state_e      state, state_nxt;
    cmd_mode_e        mode_q, cmd_mode;
    logic [ADR_W-1:0] cnt_q;
    logic [ADR_W-1:0] wr_adr_nxt, cur_adr_nxt, start_adr;
    logic             accept;

    vram_adr_wrap #(.ADR_W(ADR_W), .CELLS(CELLS)) u_wr_wrap (
        .adr      (o_vram_adr),
        .adr_next (wr_adr_nxt)
    );

    vram_adr_wrap #(.ADR_W(ADR_W), .CELLS(CELLS)) u_cur_wrap (
        .adr      (o_cursor_adr),
        .adr_next (cur_adr_nxt)
    );

    assign cmd_mode  = cmd_mode_e'(cmd.i_cmd_mode);
    // Off-screen start or cursor addresses are clamped to the first cell
    assign start_adr = (cmd.i_cmd_adr > LAST) ? '0 : cmd.i_cmd_adr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        cmd.o_cmd_ready = 1'b0;
        o_busy          = 1'b0;
        o_done          = 1'b0;
        accept          = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd.o_cmd_ready = 1'b1;
                accept          = cmd.i_cmd_valid;
                if (accept) begin
                    state_nxt = (cmd_mode == MODE_SETCUR) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                o_busy = 1'b1;
                if (cnt_q == '0) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                o_done    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Write port registers: the accept edge issues the first write, RUN issues the rest
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mode_q       <= MODE_FILL;
            cnt_q        <= '0;
            o_vram_we    <= 1'b0;
            o_vram_adr   <= '0;
            o_vram_data  <= '0;
            o_cram_data  <= '0;
            o_cursor_adr <= '0;
            o_cursor_on  <= 1'b1;
        end else begin
            o_vram_we <= 1'b0;
            if (accept) begin
                mode_q <= cmd_mode;
                cnt_q  <= (cmd_mode == MODE_PUTC) ? '0 : cmd.i_cmd_len;
                case (cmd_mode)
                    MODE_FILL, MODE_INCR: begin
                        o_vram_we   <= 1'b1;
                        o_vram_adr  <= start_adr;
                        o_vram_data <= cmd.i_cmd_char;
                        o_cram_data <= cmd.i_cmd_attr;
                    end
                    MODE_PUTC: begin
                        o_vram_we    <= 1'b1;
                        o_vram_adr   <= o_cursor_adr;
                        o_vram_data  <= cmd.i_cmd_char;
                        o_cram_data  <= cmd.i_cmd_attr;
                        o_cursor_adr <= cur_adr_nxt;
                    end
                    default: begin
                        o_cursor_adr <= start_adr;
                        o_cursor_on  <= cmd.i_cmd_char[0];
                    end
                endcase
            end else if (state == ST_RUN && cnt_q != '0) begin
                o_vram_we  <= 1'b1;
                o_vram_adr <= wr_adr_nxt;
                cnt_q      <= cnt_q - ADR_W'(1);
                if (mode_q == MODE_INCR) begin
                    o_vram_data <= o_vram_data + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_dma_vram_fill.sv
// tb/tb_dma_vram_fill.sv - self-checking bench for dma_vram_fill
module tb_dma_vram_fill;
    localparam int COLS  = 80;
    localparam int ROWS  = 30;
    localparam int ADR_W = 12;
    localparam int CELLS = COLS * ROWS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dma_vram_fill_if #(.ADR_W(ADR_W)) cmd_if ();

    logic [7:0]       vram_data, cram_data;
    logic [ADR_W-1:0] vram_adr, cursor_adr;
    logic             vram_we, cursor_on, busy, done;

    dma_vram_fill #(.COLS(COLS), .ROWS(ROWS), .ADR_W(ADR_W)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .cmd          (cmd_if),
        .o_vram_data  (vram_data),
        .o_cram_data  (cram_data),
        .o_vram_adr   (vram_adr),
        .o_vram_we    (vram_we),
        .o_cursor_adr (cursor_adr),
        .o_cursor_on  (cursor_on),
        .o_busy       (busy),
        .o_done       (done)
    );

    typedef struct {
        int cyc;
        int adr;
        int d;
        int a;
    } wr_t;

    typedef struct {
        int mode; int chr; int attr; int adr; int len;
        int e_nw; int e_first; int e_last; int e_lchr; int e_cur; int e_on;
    } vec_t;

    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    wr_t cap_q[$];
    wr_t exp_q[$];
    int  busy_tot = 0;
    int  done_tot = 0;
    int  done_cyc = 0;
    int  m_cur = 0;
    int  m_on  = 1;
    vec_t tbl[9];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (vram_we) cap_q.push_back(wr_t'{cyc, int'(vram_adr), int'(vram_data), int'(cram_data)});
        if (busy) busy_tot <= busy_tot + 1;
        if (done) begin
            done_tot <= done_tot + 1;
            done_cyc <= cyc;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: the list of cell writes a command should produce, and the cursor after it
    function automatic void model_cmd(input int mode, input int chr, input int attr,
                                      input int adr, input int len);
        int a;
        exp_q.delete();
        case (mode)
            0, 1: begin
                a = (adr >= CELLS) ? 0 : adr;
                for (int i = 0; i <= len; i++) begin
                    exp_q.push_back(wr_t'{i, a, (mode == 1) ? ((chr + i) % 256) : chr, attr});
                    a = (a + 1) % CELLS;
                end
            end
            2: begin
                exp_q.push_back(wr_t'{0, m_cur, chr, attr});
                m_cur = (m_cur + 1) % CELLS;
            end
            default: begin
                m_cur = (adr >= CELLS) ? 0 : adr;
                m_on  = chr % 2;
            end
        endcase
    endfunction

    task automatic drive(input int mode, input int chr, input int attr, input int adr, input int len);
        cmd_if.i_cmd_mode  = 2'(mode);
        cmd_if.i_cmd_char  = 8'(chr);
        cmd_if.i_cmd_attr  = 8'(attr);
        cmd_if.i_cmd_adr   = ADR_W'(adr);
        cmd_if.i_cmd_len   = ADR_W'(len);
        cmd_if.i_cmd_valid = 1'b1;
    endtask

    task automatic run_cmd(input int mode, input int chr, input int attr, input int adr,
                           input int len, output int base);
        int b0, d0, n_acc, k, errs, nw, ne;
        model_cmd(mode, chr, attr, adr, len);
        base = cap_q.size();
        b0   = busy_tot;
        d0   = done_tot;
        @(negedge clk);
        drive(mode, chr, attr, adr, len);
        k = 0;
        while (!cmd_if.o_cmd_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        n_acc = cyc;
        @(negedge clk);
        cmd_if.i_cmd_valid = 1'b0;
        // Scribble on the inputs to show they are ignored once accepted
        cmd_if.i_cmd_char = 8'($urandom);
        cmd_if.i_cmd_mode = 2'($urandom);
        k = 0;
        while (!done && k < len + 50) begin
            @(negedge clk);
            k++;
        end
        #1;
        nw = cap_q.size() - base;
        ne = exp_q.size();
        check("write_count", nw, ne);
        errs = 0;
        for (int i = 0; i < nw && i < ne; i++) begin
            if (cap_q[base+i].adr != exp_q[i].adr || cap_q[base+i].d != exp_q[i].d ||
                cap_q[base+i].a != exp_q[i].a || cap_q[base+i].cyc != n_acc + 1 + exp_q[i].cyc)
                errs++;
        end
        check("write_content", errs, 0);
        check("busy_cycles", busy_tot - b0, ne);
        check("done_pulses", done_tot - d0, 1);
        check("done_cycle", done_cyc - n_acc, ne + 1);
        check("cursor_adr", int'(cursor_adr), m_cur);
        check("cursor_on", int'(cursor_on), m_on);
        if (ne > 0) check("adr_hold", int'(vram_adr), exp_q[ne-1].adr);
    endtask

    initial begin
        int base, nw, k, d0, acc1, acc2, nacc, mode, len;

        tbl[0] = '{0, 8'h41, 8'h07, 0,    79,   80,   0,    79,   8'h41, 0,    1};
        tbl[1] = '{1, 8'hFE, 8'h1E, 2398, 3,    4,    2398, 1,    8'h01, 0,    1};
        tbl[2] = '{3, 8'h01, 8'h00, 2399, 0,    0,    0,    0,    0,     2399, 1};
        tbl[3] = '{2, 8'h5A, 8'h81, 0,    0,    1,    2399, 2399, 8'h5A, 0,    1};
        tbl[4] = '{3, 8'h00, 8'h00, 3000, 0,    0,    0,    0,    0,     0,    0};
        tbl[5] = '{0, 8'h20, 8'h70, 4000, 1,    2,    0,    1,    8'h20, 0,    0};
        tbl[6] = '{1, 8'hF0, 8'h0C, 10,   300,  301,  10,   310,  8'h1C, 0,    0};
        tbl[7] = '{0, 8'h55, 8'h42, 2390, 2404, 2405, 2390, 2394, 8'h55, 0,    0};
        tbl[8] = '{2, 8'h33, 8'h07, 0,    0,    1,    0,    0,    8'h33, 1,    0};

        cmd_if.i_cmd_valid = 1'b0;
        drive(0, 0, 0, 0, 0);
        cmd_if.i_cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_we", int'(vram_we), 0);
        check("rst_busy_done", int'({busy, done}), 0);
        check("rst_data_adr", int'({vram_data, cram_data, vram_adr}), 0);
        check("rst_cursor", int'({cursor_on, cursor_adr}), 1 << ADR_W);
        check("rst_ready", int'(cmd_if.o_cmd_ready), 1);
        rst = 1'b0;

        foreach (tbl[i]) begin
            run_cmd(tbl[i].mode, tbl[i].chr, tbl[i].attr, tbl[i].adr, tbl[i].len, base);
            nw = cap_q.size() - base;
            check($sformatf("tbl%0d_nw", i), nw, tbl[i].e_nw);
            if (tbl[i].e_nw > 0 && nw == tbl[i].e_nw) begin
                check($sformatf("tbl%0d_first", i), cap_q[base].adr, tbl[i].e_first);
                check($sformatf("tbl%0d_last", i), cap_q[base+nw-1].adr, tbl[i].e_last);
                check($sformatf("tbl%0d_lchr", i), cap_q[base+nw-1].d, tbl[i].e_lchr);
            end
            check($sformatf("tbl%0d_cur", i), int'(cursor_adr), tbl[i].e_cur);
            check($sformatf("tbl%0d_on", i), int'(cursor_on), tbl[i].e_on);
        end

        for (int r = 0; r < 25; r++) begin
            mode = int'($urandom_range(0, 3));
            len  = int'($urandom_range(0, 40));
            if ($urandom_range(0, 9) == 0) len = int'($urandom_range(2390, 2410));
            run_cmd(mode, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 4095)), len, base);
        end

        // Valid held high: the second accept lands on the cycle after the done pulse
        base = cap_q.size();
        d0   = done_tot;
        nacc = 0;
        acc1 = 0;
        acc2 = 0;
        @(negedge clk);
        drive(0, 8'h11, 8'h22, 100, 2);
        k = 0;
        while (nacc < 2 && k < 40) begin
            if (cmd_if.o_cmd_ready) begin
                if (nacc == 0) acc1 = cyc;
                else acc2 = cyc;
                nacc++;
            end
            if (nacc < 2) @(negedge clk);
            k++;
        end
        @(negedge clk);
        cmd_if.i_cmd_valid = 1'b0;
        k = 0;
        while (done_tot - d0 < 2 && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("held_accepts", nacc, 2);
        check("held_spacing", acc2 - acc1, 5);
        check("held_writes", cap_q.size() - base, 6);
        check("held_dones", done_tot - d0, 2);

        // Reset in the middle of a long fill
        base = cap_q.size();
        d0   = done_tot;
        @(negedge clk);
        drive(0, 8'h77, 8'h12, 5, 100);
        k = 0;
        while (!cmd_if.o_cmd_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        cmd_if.i_cmd_valid = 1'b0;
        k = 0;
        while (cap_q.size() - base < 10 && k < 50) begin
            @(negedge clk);
            #1;
            k++;
        end
        rst = 1'b1;
        #1;
        check("mid_rst_we", int'(vram_we), 0);
        check("mid_rst_busy_done", int'({busy, done}), 0);
        check("mid_rst_data_adr", int'({vram_data, cram_data, vram_adr}), 0);
        check("mid_rst_cursor", int'({cursor_on, cursor_adr}), 1 << ADR_W);
        m_cur = 0;
        m_on  = 1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_ready", int'(cmd_if.o_cmd_ready), 1);
        repeat (20) @(negedge clk);
        #1;
        check("mid_rst_writes", cap_q.size() - base, 10);
        check("mid_rst_no_done", done_tot - d0, 0);

        run_cmd(2, 8'h3C, 8'h0F, 0, 0, base);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
